// File: rtl/board_pkg.sv
// Shared types and constants for the tile-board write engine.
package board_pkg;

    localparam int BOARD_COLS  = 40;
    localparam int BOARD_ROWS  = 30;
    localparam int BOARD_CELLS = 1200;
    localparam int TILE_W      = 5;
    localparam int ROW_W       = 5;
    localparam int COL_W       = 6;
    localparam int ADDR_W      = 11;

    localparam logic [ROW_W-1:0]  ROW_LIMIT = 5'd30;
    localparam logic [COL_W-1:0]  COL_LIMIT = 6'd40;
    localparam logic [ADDR_W-1:0] COLS_M1   = 11'd39;
    localparam logic [ADDR_W-1:0] LAST_CELL = 11'd1199;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 11'd1;

    typedef enum logic [1:0] {
        OP_WRITE    = 2'd0,
        OP_FILL_ROW = 2'd1,
        OP_FILL_ALL = 2'd2,
        OP_RSVD     = 2'd3
    } op_e;

    typedef struct packed {
        op_e               op;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [TILE_W-1:0] tile;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_FILL  = 2'd2
    } state_e;

    // row*40 built from shifts so no multiplier is inferred
    function automatic logic [ADDR_W-1:0] row_base(input logic [ROW_W-1:0] row);
        logic [ADDR_W-1:0] r;
        r = {6'd0, row};
        return (r << 5) + (r << 3);
    endfunction

endpackage

// File: rtl/board_cmd_fifo.sv
// Command FIFO with registered full/empty flags; a push while full is refused.
module board_cmd_fifo
    import board_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic push_i,
    input  cmd_t wdata_i,
    input  logic pop_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    cmd_t          mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d, empty_q, empty_d;
    logic          do_push_s, do_pop_s;

    // Pointer and flag next-state
    always_comb begin
        do_push_s = push_i && !full_q;
        do_pop_s  = pop_i && !empty_q;
        if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
        else           wr_ptr_d = wr_ptr_q;
        if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        else           rd_ptr_d = rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10: begin
                empty_d = 1'b0;
                full_d  = (wr_ptr_d == rd_ptr_q);
            end
            2'b01: begin
                full_d  = 1'b0;
                empty_d = (rd_ptr_d == wr_ptr_q);
            end
            default: begin
                full_d  = full_q;
                empty_d = empty_q;
            end
        endcase
    end

    // Pointer and flag registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array
    always_ff @(posedge clock) begin
        if (do_push_s) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/board_writer.sv
// Board RAM write engine: buffers tile commands and issues at most one write per clock.
// Optional BOARD_VBLANK_WRITE_EN restricts writes to vertical-blank cycles.
module board_writer
    import board_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ROW_W-1:0]    cmd_row,
    input  logic [COL_W-1:0]    cmd_col,
    input  logic [TILE_W-1:0]   cmd_tile,
    input  logic                vblank,
    output logic [ADDR_W-1:0]   wraddress,
    output logic [TILE_W-1:0]   data,
    output logic                wren,
    output logic                busy,
    output logic                err
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d, end_q, end_d;
    logic [TILE_W-1:0]   tile_q, tile_d;
    logic                err_q, err_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TILE_W-1:0]   data_q, data_d;

    cmd_t                cmd_in_s, head_s;
    logic                full_s, empty_s, push_s, pop_s, go_s, pending_s, legal_s;
    logic                issue_s;
    logic [ADDR_W-1:0]   issue_addr_s, start_s, last_s, base_s;
    logic [TILE_W-1:0]   issue_tile_s;

`ifdef BOARD_VBLANK_WRITE_EN
    assign go_s = vblank;
`else
    logic vblank_unused_s;
    assign vblank_unused_s = vblank;
    assign go_s = 1'b1;
`endif

    // Pack the command fields for the FIFO
    always_comb begin
        cmd_in_s.op   = op_e'(cmd_op);
        cmd_in_s.row  = cmd_row;
        cmd_in_s.col  = cmd_col;
        cmd_in_s.tile = cmd_tile;
    end

    assign cmd_ready = !full_s && !reset;
    assign push_s    = cmd_valid && cmd_ready;

    board_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_s),
        .wdata_i (cmd_in_s),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    // cnt_q is the next address still to be written; the active command is done once it passes end_q
    assign pending_s = (state_q != ST_IDLE) && (cnt_q <= end_q);

    // State and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            end_q   <= '0;
            tile_q  <= '0;
            err_q   <= 1'b0;
            wren_q  <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            end_q   <= end_d;
            tile_q  <= tile_d;
            err_q   <= err_d;
            wren_q  <= wren_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state: continue the active command, otherwise pop and decode the FIFO head
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        end_d        = end_q;
        tile_d       = tile_q;
        err_d        = err_q;
        pop_s        = 1'b0;
        issue_s      = 1'b0;
        issue_addr_s = cnt_q;
        issue_tile_s = tile_q;
        base_s       = row_base(head_s.row);
        case (head_s.op)
            OP_WRITE: begin
                legal_s = (head_s.row < ROW_LIMIT) && (head_s.col < COL_LIMIT);
                start_s = base_s + {5'd0, head_s.col};
                last_s  = start_s;
            end
            OP_FILL_ROW: begin
                legal_s = (head_s.row < ROW_LIMIT);
                start_s = base_s;
                last_s  = base_s + COLS_M1;
            end
            OP_FILL_ALL: begin
                legal_s = 1'b1;
                start_s = 11'd0;
                last_s  = LAST_CELL;
            end
            default: begin
                legal_s = 1'b0;
                start_s = 11'd0;
                last_s  = 11'd0;
            end
        endcase
        if (pending_s) begin
            if (go_s) begin
                issue_s = 1'b1;
                cnt_d   = cnt_q + ADDR_ONE;
            end else begin
                issue_s = 1'b0;
            end
        end else if (!empty_s) begin
            pop_s = 1'b1;
            if (!legal_s) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
            end else begin
                tile_d       = head_s.tile;
                end_d        = last_s;
                state_d      = (head_s.op == OP_WRITE) ? ST_WRITE : ST_FILL;
                issue_addr_s = start_s;
                issue_tile_s = head_s.tile;
                if (go_s) begin
                    issue_s = 1'b1;
                    cnt_d   = start_s + ADDR_ONE;
                end else begin
                    cnt_d   = start_s;
                end
            end
        end else begin
            state_d = ST_IDLE;
        end
    end

    // Output next-state: address and data hold between writes
    always_comb begin
        wren_d = issue_s;
        if (issue_s) begin
            addr_d = issue_addr_s;
            data_d = issue_tile_s;
        end else begin
            addr_d = addr_q;
            data_d = data_q;
        end
    end

    assign wren      = wren_q;
    assign wraddress = addr_q;
    assign data      = data_q;
    assign err       = err_q;
    assign busy      = !empty_s || (state_q != ST_IDLE);

endmodule

// File: tb/tb_board_writer.sv
// Self-checking bench for board_writer: directed and randomized tile commands against a write-list model.
module tb_board_writer;

    logic        clock = 1'b0;
    logic        reset, cmd_valid, cmd_ready, vblank, wren, busy, err;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_row, cmd_tile, data;
    logic [5:0]  cmd_col;
    logic [10:0] wraddress;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int got_addr[$], got_data[$], got_cyc[$];
    int exp_addr[$], exp_data[$];
    bit exp_err  = 1'b0;

    board_writer dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_tile  (cmd_tile),
        .vblank    (vblank),
        .wraddress (wraddress),
        .data      (data),
        .wren      (wren),
        .busy      (busy),
        .err       (err)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (wren === 1'b1) begin
            got_addr.push_back(int'(wraddress));
            got_data.push_back(int'(data));
            got_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: each command expands to its list of (address, tile) writes
    task automatic expand(input int op, input int row, input int col, input int tile);
        if (op == 0) begin
            if (row < 30 && col < 40) begin
                exp_addr.push_back(row * 40 + col);
                exp_data.push_back(tile);
            end else exp_err = 1'b1;
        end else if (op == 1) begin
            if (row < 30) begin
                for (int c = 0; c < 40; c++) begin
                    exp_addr.push_back(row * 40 + c);
                    exp_data.push_back(tile);
                end
            end else exp_err = 1'b1;
        end else if (op == 2) begin
            for (int a = 0; a < 1200; a++) begin
                exp_addr.push_back(a);
                exp_data.push_back(tile);
            end
        end else exp_err = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after acceptance with acc = that cycle
    task automatic send(input int op, input int row, input int col, input int tile, output int acc);
        bit accepted;
        accepted  = 1'b0;
        cmd_op    = 2'(op);
        cmd_row   = 5'(row);
        cmd_col   = 6'(col);
        cmd_tile  = 5'(tile);
        cmd_valid = 1'b1;
        for (int t = 0; t < 3000; t++) begin
            if (cmd_ready === 1'b1) begin
                @(posedge clock);
                accepted = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (accepted) @(negedge clock);
        cmd_valid = 1'b0;
        acc = cyc;
        chk("send_accept", 32'(accepted), 32'd1);
        if (accepted) expand(op, row, col, tile);
    endtask

    task automatic wait_idle(input int max_cyc);
        for (int t = 0; t < max_cyc; t++) begin
            if (busy === 1'b0) break;
            @(negedge clock);
        end
        chk("drain_busy", 32'(busy), 32'd0);
        @(negedge clock);
    endtask

    task automatic compare_writes(input string tag, input bit check_gaps);
        int n, gaps;
        chk($sformatf("%s_count", tag), 32'(got_addr.size()), 32'(exp_addr.size()));
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_addr[%0d]", tag, i), 32'(got_addr[i]), 32'(exp_addr[i]));
            chk($sformatf("%s_data[%0d]", tag, i), 32'(got_data[i]), 32'(exp_data[i]));
        end
        if (check_gaps) begin
            gaps = 0;
            for (int i = 1; i < got_cyc.size(); i++)
                if (got_cyc[i] != got_cyc[i-1] + 1) gaps++;
            chk($sformatf("%s_gaps", tag), 32'(gaps), 32'd0);
        end
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        exp_addr.delete(); exp_data.delete();
    endtask

    initial begin
        int acc, op, row, col, tile;
        reset = 1'b1; cmd_valid = 1'b0; vblank = 1'b1;
        cmd_op = 2'd0; cmd_row = 5'd0; cmd_col = 6'd0; cmd_tile = 5'd0;
        repeat (3) @(negedge clock);
        chk("rst_wren", 32'(wren), 32'd0);
        chk("rst_addr", 32'(wraddress), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clock);

        // Single WRITE: latency and address
        send(0, 2, 3, 7, acc);
        wait_idle(20);
        chk("w1_cycle", 32'(got_cyc.size() > 0 ? got_cyc[0] : -1), 32'(acc + 1));
        compare_writes("w1", 1'b0);
        chk("w1_err", 32'(err), 32'd0);

        // FILL_ROW on the last row
        send(1, 29, 0, 4, acc);
        wait_idle(100);
        compare_writes("fill_row29", 1'b1);

        // FILL_ALL with four WRITEs queued behind it
        send(2, 0, 0, 1, acc);
        for (int i = 0; i < 4; i++)
            send(0, $urandom_range(0, 29), $urandom_range(0, 39), $urandom_range(0, 31), acc);
        chk("full_ready", 32'(cmd_ready), 32'd0);
        wait_idle(1400);
        compare_writes("fill_all_q4", 1'b1);

        // Illegal commands set the sticky error and write nothing
        send(0, 0, 40, 9, acc);
        send(3, $urandom_range(0, 31), $urandom_range(0, 63), $urandom_range(0, 31), acc);
        wait_idle(20);
        compare_writes("illegal", 1'b0);
        chk("err_set", 32'(err), 32'(exp_err));
        repeat (5) @(negedge clock);
        chk("err_sticky", 32'(err), 32'd1);
        send(0, 29, 39, 31, acc);
        wait_idle(20);
        compare_writes("after_err", 1'b0);

        // Randomized mix, including out-of-range fields
        for (int i = 0; i < 12; i++) begin
            op   = $urandom_range(0, 3);
            row  = $urandom_range(0, 31);
            col  = $urandom_range(0, 63);
            tile = $urandom_range(0, 31);
            send(op, row, col, tile, acc);
        end
        wait_idle(20000);
        compare_writes("random", 1'b0);
        chk("random_err", 32'(err), 32'(exp_err));

        // FILL_ROW while vblank toggles 10 on / 10 off
        send(1, $urandom_range(0, 29), 0, $urandom_range(0, 31), acc);
        for (int t = 0; t < 300; t++) begin
            vblank = ((t / 10) % 2) == 0;
            if (busy === 1'b0) break;
            @(negedge clock);
        end
        vblank = 1'b1;
        wait_idle(20);
`ifdef BOARD_VBLANK_WRITE_EN
        compare_writes("vblank_fill", 1'b0);
`else
        compare_writes("vblank_fill", 1'b1);
`endif

        // Reset in the middle of a FILL_ALL
        send(2, 0, 0, 3, acc);
        for (int t = 0; t < 700; t++) begin
            if (got_addr.size() >= 500) break;
            @(negedge clock);
        end
        chk("mid_fill_addr", 32'(got_addr.size() >= 500 ? got_addr[499] : -1), 32'd499);
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        chk("async_wren", 32'(wren), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_err", 32'(err), 32'd0);
        chk("async_ready", 32'(cmd_ready), 32'd0);
        chk("async_addr", 32'(wraddress), 32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b0;
        got_addr.delete(); got_data.delete(); got_cyc.delete();
        exp_addr.delete(); exp_data.delete();
        exp_err = 1'b0;
        repeat (50) @(negedge clock);
        compare_writes("post_reset", 1'b0);
        chk("post_reset_busy", 32'(busy), 32'd0);
        chk("post_reset_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/board_writer.md
Name: board_writer

Overview:
- Write-side engine for the 40x30 tile board RAM. The pixel pipeline reads that RAM through its read port; this block owns the write port.
- Game logic issues tile commands over a valid/ready interface: single-cell write, row fill and full-board fill.
- Commands are buffered in a 4-entry FIFO and drained by an FSM that issues at most one RAM write per clock.

Parameters:
- COLS, 40, board width in tiles.
- ROWS, 30, board height in tiles.
- TILE_W, 5, tile index width; matches the board RAM data width.
- FIFO_DEPTH, 4, command FIFO entries; must be a power of 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO can accept a command.
- cmd_op  in  2  command opcode: 0 WRITE, 1 FILL_ROW, 2 FILL_ALL, 3 reserved.
- cmd_row  in  5  target row; ignored for FILL_ALL.
- cmd_col  in  6  target column; used by WRITE only.
- cmd_tile  in  5  tile index to write.
- vblank  in  1  display vertical blank; used only with the optional feature.
- wraddress  out  11  board RAM write address.
- data  out  5  board RAM write data.
- wren  out  1  board RAM write enable.
- busy  out  1  FIFO non-empty or FSM not IDLE.
- err  out  1  sticky flag: a command was dropped.

Behaviour:
- Reset (asynchronous, immediate) forces: wren=0, wraddress=0, data=0, err=0, busy=0, FIFO empty, FSM=IDLE, cmd_ready=0 while reset is asserted.
- After reset deassertion: cmd_ready = !fifo_full.
- Handshake: a command is accepted on a rising edge where cmd_valid && cmd_ready. The producer holds cmd fields stable until accepted.
- Simultaneous push and pop on a full FIFO: the push is refused, because cmd_ready is computed from the registered full flag.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop and decode the command.
  - WRITE: one cycle. Go to IDLE, or pop the next command directly if one is available.
  - FILL: a counter cnt and an end value; one write per cycle.
- Command decode:
  - WRITE: requires row<ROWS and col<COLS. Target address = row*COLS + col.
  - FILL_ROW: requires row<ROWS. Writes addresses row*COLS .. row*COLS+COLS-1 in ascending order.
  - FILL_ALL: writes addresses 0 .. ROWS*COLS-1 (0..1199) in ascending order.
  - Out-of-range coordinates or opcode 3: the command is popped, no write occurs, err is set to 1. The command consumes one cycle in IDLE.
- Outputs are registered. On each write cycle: wren=1, wraddress=address, data=tile. In every other cycle wren=0, and wraddress/data hold their last values.
- Latency: a WRITE accepted at edge k, with the FIFO empty and the FSM in IDLE, produces wren=1 in the cycle after edge k+1.
- Throughput:
  - Back-to-back WRITEs: one write per cycle.
  - FILL_ROW: 40 write cycles.
  - FILL_ALL: 1200 write cycles.
- The last FILL write and the next command's pop may occur on the same edge; there is no bubble.
- Address arithmetic is 11 bits. row*40 is computed as (row<<5)+(row<<3). The maximum address is 1199; no wrap occurs.
- err clears only on reset.

Optional Feature:
- BOARD_VBLANK_WRITE_EN defined:
  - Writes are issued only in cycles where vblank=1, to avoid tearing.
  - A FILL in progress pauses when vblank=0: cnt holds and wren=0. It resumes when vblank returns.
  - WRITE waits in its state until vblank=1.
- Not defined: the vblank input is ignored and writes proceed every cycle.

Decomposition:
- Package board_pkg:
  - BOARD_COLS=40, BOARD_ROWS=30, BOARD_CELLS=1200.
  - TILE_W.
  - Opcode enum: OP_WRITE, OP_FILL_ROW, OP_FILL_ALL.
  - Command struct typedef {op, row, col, tile}.
  - FSM state enum.
- Sub-module board_cmd_fifo: synchronous FIFO with registered full/empty flags.

Test Plan:
- Reset, then WRITE row=2 col=3 tile=7 -> exactly one cycle with wren=1, wraddress=83, data=7, 2 cycles after acceptance; busy returns to 0.
- FILL_ROW row=29 tile=4 -> 40 consecutive wren cycles, addresses 1160..1199, data=4; no write outside that range.
- FILL_ALL tile=1, with 4 WRITEs queued behind it -> cmd_ready=0 after the 4th push. 1200 fill writes, then 4 writes with no idle cycle between them.
- WRITE col=40 row=0, then opcode 3 -> no wren; err=1 and stays 1; a following valid WRITE executes normally.
- Reset asserted mid-FILL_ALL (cnt≈500) -> wren drops immediately without waiting for a clock edge; FIFO empty; err=0; no writes after release.
- With BOARD_VBLANK_WRITE_EN: FILL_ROW with vblank toggling 10 cycles on / 10 off -> writes only in vblank=1 cycles, contiguous addresses, total 40.
